fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter FETCH_W, default 2: instructions per fetch group; legal values 1, 2, 4.
REQ-002 SHALL have parameter DEPTH, default 4: fetch-queue entries (groups); power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-004 SHALL have ports in this order:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- StallF  in  1  freezes PC and enqueue.
- Ihit, Dhit  in  1 each  cache hits; a fetch is accepted only when both are 1.
- JumpReg, PCReg  in  1, 32  back-end register-jump redirect and its target.
- MistakeD, PCBranchD  in  1, 32  back-end mispredict redirect and its target.
- BranchPrd, PCBranchF  in  1, 32  front-end predicted-taken redirect and its target.
- Jump, PCJump  in  1, 32  front-end direct-jump redirect and its target.
- PC  out  32  current fetch address to I-cache.
- InstF  in  32*FETCH_W  I-cache data; slot i is the instruction at PC+4i.
- DeqValid  out  1  head group valid.
- DeqReady  in  1  decode accepts head group.
- DeqInst  out  32*FETCH_W  head group instructions.
- DeqPC  out  32  head group base PC.
- Count  out  $clog2(DEPTH+1)  queue occupancy.

Function
REQ-005 SHALL define Flush = JumpReg | MistakeD.
REQ-006 SHALL define Accept = Ihit & Dhit & ~StallF & ~Flush & (Count<DEPTH | (DeqValid & DeqReady)).
REQ-007 SHALL select the next PC by priority: JumpReg->PCReg; MistakeD->PCBranchD; Accept&BranchPrd->PCBranchF; Accept&Jump->PCJump; Accept->PC+4*FETCH_W (mod 2^32); else hold PC.
REQ-008 SHALL apply Flush regardless of StallF, Ihit, Dhit and queue state.
REQ-009 SHALL, on Accept, enqueue {PC, InstF} at the tail in the same edge.
REQ-010 SHALL, on DeqValid & DeqReady & ~Flush, pop the head group.
REQ-011 SHALL, on Flush, empty the queue (Count<=0) and force DeqValid to 0 in that cycle; no pop is reported.
REQ-012 SHALL, when full with simultaneous pop, accept the enqueue; Count stays DEPTH.
REQ-013 SHALL keep Count unchanged on simultaneous enqueue and pop; +1 on enqueue only; -1 on pop only.
REQ-014 SHALL wrap head/tail pointers modulo DEPTH.
REQ-015 SHALL hold DeqInst/DeqPC stable while DeqValid=1 and DeqReady=0.
REQ-016 SHALL keep DeqInst/DeqPC don't-care while DeqValid=0.
REQ-017 SHALL implement a state machine RUN/STALL/REDIR: RUN when last cycle accepted; STALL when Accept=0 without Flush; REDIR for exactly one cycle after Flush, during which Accept is blocked and PC is presented at the redirect target (one-cycle refill bubble); REDIR->RUN or STALL by the same rules.

Reset
REQ-018 SHALL, on reset, set PC=RESET_PC, Count=0, DeqValid=0, pointers=0, state=RUN.
REQ-019 SHALL give reset priority over Flush, Accept and pop, including mid-stall and mid-redirect.

Configuration
REQ-020 SHALL, with FETCH_BYPASS_EN defined, present an accepted group on DeqInst/DeqPC with DeqValid=1 in the same cycle when the queue is empty; if DeqReady=1 it is consumed without being stored.
REQ-021 SHALL, without FETCH_BYPASS_EN, show an enqueued group on Deq* no earlier than the cycle after Accept.

Verification
REQ-022 SHALL cover: reset, FETCH_W=2, Ihit=Dhit=1, DeqReady=1 -> PC 0,8,16,...; DeqPC 0 one cycle after first Accept (no bypass).
REQ-023 SHALL cover: DeqReady=0 for 6 cycles, DEPTH=4 -> Count reaches 4, PC holds at 32, Accept=0, state STALL.
REQ-024 SHALL cover: queue full, DeqReady=1 and Ihit=1 same cycle -> Count stays 4, PC advances by 8.
REQ-025 SHALL cover: MistakeD=1 with PCBranchD=0x100 while BranchPrd=1, Count=3 -> next PC=0x100, Count=0, DeqValid=0 that cycle, one REDIR bubble.
REQ-026 SHALL cover: JumpReg=1 with PCReg=0x200 and MistakeD=1 with PCBranchD=0x100 same cycle -> PC=0x200.
REQ-027 SHALL cover: FETCH_BYPASS_EN defined, empty queue, Accept at PC=0x40 -> DeqValid=1, DeqPC=0x40 same cycle; Count stays 0 when DeqReady=1.

Source files
------------

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Front-end fetch PC generator plus a small circular queue of fetch groups
//   sitting between the I-cache and decode.
//
//   Each accepted fetch enqueues one group {PC, InstF} (FETCH_W instructions).
//   Decode drains groups through a valid/ready handshake on the Deq* ports.
//   A back-end redirect (JumpReg or MistakeD) flushes the queue. It also
//   forces a one-cycle REDIR bubble while the I-cache looks up the new target.
//
//   Optional feature (compile-time macro FETCH_BYPASS_EN):
//     When the queue is empty, an accepted group is shown on Deq* in the same
//     cycle. If decode takes it at once, it is never written into the queue.
//
// Parameters
//   FETCH_W   instructions per fetch group (1, 2 or 4)
//   DEPTH     queue entries in groups (power of two, >= 2)
//   RESET_PC  fetch address after reset
//
// Ports
//   clk                    clock, all state on the rising edge
//   reset                  synchronous active-high reset
//   StallF                 freezes PC and enqueue
//   Ihit, Dhit             cache hits; fetch is accepted only when both are 1
//   JumpReg, PCReg         back-end register-jump redirect and its target
//   MistakeD, PCBranchD    back-end mispredict redirect and its target
//   BranchPrd, PCBranchF   front-end predicted-taken redirect and its target
//   Jump, PCJump           front-end direct-jump redirect and its target
//   PC                     current fetch address to the I-cache
//   InstF                  I-cache data; slot i is the instruction at PC+4i
//   DeqValid/DeqReady      head-group handshake with decode
//   DeqInst, DeqPC         head-group instructions and base PC
//   Count                  queue occupancy in groups
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int          FETCH_W  = 2,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         StallF,
    input  logic                         Ihit,
    input  logic                         Dhit,
    input  logic                         JumpReg,
    input  logic [31:0]                  PCReg,
    input  logic                         MistakeD,
    input  logic [31:0]                  PCBranchD,
    input  logic                         BranchPrd,
    input  logic [31:0]                  PCBranchF,
    input  logic                         Jump,
    input  logic [31:0]                  PCJump,
    output logic [31:0]                  PC,
    input  logic [32*FETCH_W-1:0]        InstF,
    output logic                         DeqValid,
    input  logic                         DeqReady,
    output logic [32*FETCH_W-1:0]        DeqInst,
    output logic [31:0]                  DeqPC,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int GW = 32 * FETCH_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [31:0]   PC_STEP  = 32'(4 * FETCH_W);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_REDIR = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic            fetch_en_s;

    logic [31:0]     pc_r;
    logic [31:0]     next_pc_s;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [GW-1:0]   inst_mem_r [DEPTH];
    logic [31:0]     pc_mem_r   [DEPTH];

    logic            flush_s;
    logic            room_s;
    logic            accept_s;
    logic            bypass_s;
    logic            enq_s;
    logic            pop_s;

    assign PC    = pc_r;
    assign Count = count_r;

    // FSM state register: REDIR marks the refill bubble after a back-end redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: identical rules from every state, flush dominates
    always_comb begin
        state_next_s = state_r;
        if (flush_s) begin
            state_next_s = ST_REDIR;
        end else if (accept_s) begin
            state_next_s = ST_RUN;
        end else begin
            state_next_s = ST_STALL;
        end
    end

    // FSM outputs: fetching is blocked only during the redirect bubble
    always_comb begin
        fetch_en_s = 1'b0;
        case (state_r)
            ST_RUN:   fetch_en_s = 1'b1;
            ST_STALL: fetch_en_s = 1'b1;
            ST_REDIR: fetch_en_s = 1'b0;
            default:  fetch_en_s = 1'b0;
        endcase
    end

    // Accept/handshake decode.
    // A full queue makes room only by popping. When full, the head is valid
    // unless a flush is active, and accept already excludes flush. So DeqReady
    // alone stands in for DeqValid & DeqReady here, which keeps the bypass path
    // free of a combinational loop.
    always_comb begin
        flush_s  = JumpReg | MistakeD;
        room_s   = (count_r != CNT_FULL) | DeqReady;
        accept_s = Ihit & Dhit & ~StallF & ~flush_s & fetch_en_s & room_s;
`ifdef FETCH_BYPASS_EN
        bypass_s = (count_r == CNT_ZERO) & accept_s;
`else
        bypass_s = 1'b0;
`endif
        DeqValid = ((count_r != CNT_ZERO) | bypass_s) & ~flush_s;
        if (bypass_s) begin
            DeqInst = InstF;
            DeqPC   = pc_r;
        end else begin
            DeqInst = inst_mem_r[head_r];
            DeqPC   = pc_mem_r[head_r];
        end
        // a bypassed group taken by decode at once is never stored
        pop_s = DeqValid & DeqReady & (count_r != CNT_ZERO);
        enq_s = accept_s & ~(bypass_s & DeqReady);
    end

    // Next fetch address: back-end redirects first, then front-end predictions
    always_comb begin
        next_pc_s = pc_r;
        if (JumpReg) begin
            next_pc_s = PCReg;
        end else if (MistakeD) begin
            next_pc_s = PCBranchD;
        end else if (accept_s && BranchPrd) begin
            next_pc_s = PCBranchF;
        end else if (accept_s && Jump) begin
            next_pc_s = PCJump;
        end else if (accept_s) begin
            next_pc_s = pc_r + PC_STEP;
        end else begin
            next_pc_s = pc_r;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Queue pointers and occupancy; reset outranks flush, which outranks traffic
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else if (flush_s) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({enq_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage: payload needs no reset, validity comes from count_r
    always_ff @(posedge clk) begin
        if (enq_s && !reset && !flush_s) begin
            inst_mem_r[tail_r] <= InstF;
            pc_mem_r[tail_r]   <= pc_r;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

    localparam int FETCH_W = 2;
    localparam int DEPTH   = 4;
    localparam int GW      = 32 * FETCH_W;
    localparam int CW      = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              StallF, Ihit, Dhit;
    logic              JumpReg, MistakeD, BranchPrd, Jump;
    logic [31:0]       PCReg, PCBranchD, PCBranchF, PCJump;
    logic [31:0]       PC;
    logic [GW-1:0]     InstF;
    logic              DeqValid;
    logic              DeqReady;
    logic [GW-1:0]     DeqInst;
    logic [31:0]       DeqPC;
    logic [CW-1:0]     Count;

    // bench reference state
    logic [31:0]       m_pc;
    bit                m_redir;
    logic [GW+31:0]    sb_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    fetch_buffer #(
        .FETCH_W (FETCH_W),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .StallF   (StallF),
        .Ihit     (Ihit),
        .Dhit     (Dhit),
        .JumpReg  (JumpReg),
        .PCReg    (PCReg),
        .MistakeD (MistakeD),
        .PCBranchD(PCBranchD),
        .BranchPrd(BranchPrd),
        .PCBranchF(PCBranchF),
        .Jump     (Jump),
        .PCJump   (PCJump),
        .PC       (PC),
        .InstF    (InstF),
        .DeqValid (DeqValid),
        .DeqReady (DeqReady),
        .DeqInst  (DeqInst),
        .DeqPC    (DeqPC),
        .Count    (Count)
    );

    // I-cache content model: each word is a fixed function of its own address
    function automatic logic [GW-1:0] icache(input logic [31:0] a);
        logic [GW-1:0] g;
        for (int i = 0; i < FETCH_W; i++) begin
            g[32*i +: 32] = ~(a + 32'(4 * i)) ^ 32'h1357_9BDF;
        end
        return g;
    endfunction

    // I-cache data follows the presented fetch address
    always_comb InstF = icache(PC);

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_redirects();
        JumpReg   = 1'b0; PCReg     = 32'h0;
        MistakeD  = 1'b0; PCBranchD = 32'h0;
        BranchPrd = 1'b0; PCBranchF = 32'h0;
        Jump      = 1'b0; PCJump    = 32'h0;
    endtask

    task automatic drive(input bit ih, input bit dh, input bit st, input bit rd);
        Ihit = ih; Dhit = dh; StallF = st; DeqReady = rd;
    endtask

    // one reset cycle with whatever inputs are currently driven; ends at a negedge
    task automatic reset_dut();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_redirects();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.delete();
        m_pc    = 32'h0;
        m_redir = 1'b0;
    endtask

    // check the current cycle against the reference, advance it, move to next negedge
    task automatic step();
        bit             flush, acc, exp_valid;
        int             nsz;
        logic [GW+31:0] e;
        #1;
        flush = JumpReg || MistakeD;
        nsz   = sb_q.size();
        acc   = Ihit && Dhit && !StallF && !flush && !m_redir &&
                ((nsz < DEPTH) || (nsz > 0 && DeqReady));
`ifdef FETCH_BYPASS_EN
        exp_valid = (nsz > 0 || acc) && !flush;
`else
        exp_valid = (nsz > 0) && !flush;
`endif
        check_eq("pc", PC, m_pc);
        check_eq("count", Count, nsz);
        check_eq("deq_valid", DeqValid, exp_valid);
        if (flush) begin
            sb_q.delete();
        end else begin
            if (acc) sb_q.push_back({m_pc, icache(m_pc)});
            if (exp_valid) begin
                e = sb_q[0];
                check_eq("deq_pc", DeqPC, e[GW+31:GW]);
                check_eq("deq_inst", DeqInst, e[GW-1:0]);
                if (DeqReady) void'(sb_q.pop_front());
            end
        end
        if (JumpReg)               m_pc = PCReg;
        else if (MistakeD)         m_pc = PCBranchD;
        else if (acc && BranchPrd) m_pc = PCBranchF;
        else if (acc && Jump)      m_pc = PCJump;
        else if (acc)              m_pc = m_pc + 32'(4 * FETCH_W);
        m_redir = flush;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        clear_redirects();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_dut();

        // reset state
        #1;
        check_eq("rst_pc", PC, 32'h0);
        check_eq("rst_count", Count, 0);
        check_eq("rst_valid", DeqValid, 1'b0);

        // free-running fetch: PC 0,8,16,...
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            check_eq("seq_pc", PC, 32'(8 * k));
`ifndef FETCH_BYPASS_EN
            if (k == 1) check_eq("first_deq_pc", DeqPC, 32'h0);
`endif
            step();
        end

        // decode stalled: queue fills and PC parks at 32
        reset_dut();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) step();
        check_eq("full_count", Count, 4);
        check_eq("full_pc", PC, 32'd32);
        step();
        check_eq("full_pc_hold", PC, 32'd32);

        // full queue with simultaneous pop and fetch
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check_eq("full_pop_count", Count, 4);
        check_eq("full_pop_pc", PC, 32'd40);

        // mispredict flush with a front-end prediction at Count=3
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("pre_flush_count", Count, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        BranchPrd = 1'b1; PCBranchF = 32'h300;
        MistakeD  = 1'b1; PCBranchD = 32'h100;
        #1;
        check_eq("flush_valid", DeqValid, 1'b0);
        step();
        clear_redirects();
        check_eq("redir_pc", PC, 32'h100);
        check_eq("redir_count", Count, 0);
        step();
        check_eq("bubble_pc", PC, 32'h100);
        step();
        check_eq("refill_pc", PC, 32'h108);

        // register jump outranks mispredict
        JumpReg  = 1'b1; PCReg     = 32'h200;
        MistakeD = 1'b1; PCBranchD = 32'h100;
        step();
        clear_redirects();
        check_eq("jr_prio_pc", PC, 32'h200);

        // empty queue accept at 0x40 (bypass or one-cycle latency)
        JumpReg = 1'b1; PCReg = 32'h40;
        step();
        clear_redirects();
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
`ifdef FETCH_BYPASS_EN
        check_eq("byp_valid", DeqValid, 1'b1);
        check_eq("byp_pc", DeqPC, 32'h40);
        step();
        check_eq("byp_count", Count, 0);
`else
        check_eq("nobyp_valid", DeqValid, 1'b0);
        step();
        check_eq("nobyp_count", Count, 1);
        check_eq("nobyp_deq_pc", DeqPC, 32'h40);
`endif

        // sequential PC wraps modulo 2^32
        JumpReg = 1'b1; PCReg = 32'hFFFF_FFF8;
        step();
        clear_redirects();
        step();
        step();
        check_eq("wrap_pc", PC, 32'h0);

        // randomised traffic against the scoreboard
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            BranchPrd = ($urandom_range(0, 7) == 0); PCBranchF = $urandom();
            Jump      = ($urandom_range(0, 7) == 0); PCJump    = $urandom();
            MistakeD  = ($urandom_range(0, 19) == 0); PCBranchD = $urandom();
            JumpReg   = ($urandom_range(0, 29) == 0); PCReg     = $urandom();
            step();
        end
        clear_redirects();

        // reset mid-stall beats a simultaneous flush and fetch
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        MistakeD = 1'b1; PCBranchD = 32'h100;
        reset_dut();
        #1;
        check_eq("rst_flush_pc", PC, 32'h0);
        check_eq("rst_flush_count", Count, 0);
        check_eq("rst_flush_valid", DeqValid, 1'b0);

        // reset mid-redirect: no bubble remains afterwards
        JumpReg = 1'b1; PCReg = 32'h500;
        step();
        clear_redirects();
        reset_dut();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check_eq("rst_redir_pc", PC, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
